dmem_mmio: RTL and testbench
============================

Name: dmem_mmio

Overview:
- Data-side memory subsystem that sits directly downstream of the single-cycle RISC-V core.
- Consumes the core's MemWrite, ALUResult (used as the address) and WriteData; returns ReadData in the same cycle.
- Contains a word-addressed data RAM plus memory-mapped GPIO and a 32-bit compare timer with an interrupt output.
- Lets lab programs drive LEDs, sample switches and time events without touching core RTL.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; power of two, 16..4096.
- MMIO_BASE, 32'h0000_FF00, base address of the 32-byte MMIO window.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- MemWrite  input  1  store strobe from the core.
- ALUResult  input  32  byte address from the core.
- WriteData  input  32  store data.
- ReadData  output  32  load data, combinational from ALUResult.
- gpio_in  input  32  asynchronous external switches.
- gpio_out  output  32  LED register.
- timer_irq  output  1  timer interrupt, level.

Behaviour:
- Address decode uses ALUResult[1:0] ignored, so all accesses are whole-word.
  - RAM: ALUResult < RAM_WORDS*4; index ALUResult[log2(RAM_WORDS)+1:2].
  - MMIO: ALUResult[31:5] == MMIO_BASE[31:5]. Offsets:
    - 0x00 GPIO_OUT: RW.
    - 0x04 GPIO_IN: RO.
    - 0x10 COUNT: RW.
    - 0x14 CMP: RW.
    - 0x18 CTRL: RW; bit0 EN, bit1 AUTORELOAD, bit2 IRQ_EN, other bits read 0.
    - 0x1C STAT: bit0 MATCH, bit1 FAULT; write-1-to-clear.
  - Any other MMIO offset, or any address outside RAM and MMIO, is unmapped.
- Reads are combinational, with zero latency.
  - Unmapped reads return 32'h0 and have no side effects.
  - Reads never modify state.
- Writes take effect on the rising clk edge while MemWrite=1.
  - Writes to RO registers are ignored.
  - Unmapped writes are ignored and set FAULT (sticky).
- RAM is not reset; its contents are undefined until written. RAM is a synchronous-write, asynchronous-read array.
- Reset (reset=0) acts immediately, independent of clk:
  - GPIO_OUT, COUNT, CTRL, MATCH, FAULT and both synchronizer stages go to 0.
  - CMP goes to 32'hFFFF_FFFF.
  - Hence gpio_out=0 and timer_irq=0. Reset mid-count discards all timer state.
- GPIO_IN is gpio_in passed through a 2-flop synchronizer; a change on the pins is visible on reads 2 rising edges later.
- Timer update per edge, in priority order:
  1. CPU write to COUNT: COUNT <= WriteData. This beats increment and reload.
  2. Else if EN=1 and COUNT==CMP: MATCH <= 1; COUNT <= AUTORELOAD ? 0 : COUNT+1.
  3. Else if EN=1: COUNT <= COUNT+1.
  - COUNT+1 wraps modulo 2^32 (FFFF_FFFF -> 0); wrap alone does not set MATCH.
  - With EN=0, COUNT holds and no match is detected.
  - Compare uses the pre-edge COUNT and CMP. A CMP write in the match cycle does not affect that cycle's compare.
- STAT write-1-to-clear clears the bits that are 1 in WriteData[1:0]. If a set event (match or fault) coincides with a clear of the same bit, the set wins.
- timer_irq = MATCH & IRQ_EN. It is combinational from registers and stays high until MATCH is cleared or IRQ_EN=0.
- FAULT is set only by writes. Unmapped reads never set it.

Test Plan:
- Reset, then reads: pulse reset low mid-operation with EN=1 -> gpio_out=0, timer_irq=0, CTRL=0, COUNT=0, CMP=FFFF_FFFF immediately without a clk edge. Read 0xFF18 -> 0. Read 0x2000 -> 0.
- RAM: write 0xDEADBEEF to 0x0C, then write 0x12345678 to 0x0D -> read 0x0C returns 0x12345678 (offset bits ignored). Read 0x08 returns the value previously written there. Read 0x08 on the edge after that write returns the new value.
- Timer one-shot: CMP=5, COUNT=0, CTRL=0x5 -> MATCH=1 and timer_irq=1 after the 6th enabled edge, with COUNT=6 and counting on. Write STAT=1 -> MATCH=0, timer_irq=0.
- Timer autoreload and priority: CMP=3, CTRL=0x3 -> COUNT sequence 0,1,2,3,0,1 with MATCH set. COUNT write of 0x100 on a match edge -> COUNT=0x100. STAT clear on a match edge -> MATCH stays 1.
- Wrap: COUNT=FFFF_FFFE, CMP=10, EN=1 -> FFFF_FFFF, 0, 1; MATCH remains 0.
- GPIO/fault: write 0xA5 to 0xFF00 -> gpio_out=0xA5. Change gpio_in to 0x3C -> a read of 0xFF04 returns 0x3C from the 2nd edge on. Write to 0xFF04 -> ignored. Write to 0x4000 -> FAULT=1, RAM unchanged, STAT reads 0x2.

Source files
------------

// File: rtl/dmem_mmio.sv
// Data-side memory for the single-cycle core: word RAM, GPIO and a compare timer behind one address port.
// Latency: reads are combinational (zero cycles); writes land on the next rising clk edge.
// Backpressure: none; every access completes in the cycle it is presented.
module dmem_mmio #(
    parameter int          RAM_WORDS = 64,
    parameter logic [31:0] MMIO_BASE = 32'h0000_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out,
    output logic        timer_irq
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;

    localparam logic [2:0] OFF_GOUT = 3'd0;
    localparam logic [2:0] OFF_GIN  = 3'd1;
    localparam logic [2:0] OFF_CNT  = 3'd4;
    localparam logic [2:0] OFF_CMP  = 3'd5;
    localparam logic [2:0] OFF_CTRL = 3'd6;
    localparam logic [2:0] OFF_STAT = 3'd7;

    logic [31:0] mem [RAM_WORDS];

    logic [31:0] gpio_q;
    logic [31:0] sync1, sync2;
    logic [31:0] count, cmp;
    logic [2:0]  ctrl;
    logic        match, fault;

    logic          ram_hit, mmio_hit, mmio_mapped;
    logic [2:0]    off;
    logic [AW-1:0] ram_idx;
    logic          wr_gout, wr_cnt, wr_cmp, wr_ctrl, wr_stat, wr_unmapped;
    logic          en, autoreload, irq_en, cmp_hit;

    assign ram_hit  = ALUResult < RAM_BYTES;
    assign ram_idx  = ALUResult[AW+1:2];
    assign mmio_hit = !ram_hit && (ALUResult[31:5] == MMIO_BASE[31:5]);
    assign off      = ALUResult[4:2];

    // Offsets 0x08 and 0x0C are holes in the window.
    assign mmio_mapped = mmio_hit && (off != 3'd2) && (off != 3'd3);

    assign wr_gout     = MemWrite && mmio_hit && (off == OFF_GOUT);
    assign wr_cnt      = MemWrite && mmio_hit && (off == OFF_CNT);
    assign wr_cmp      = MemWrite && mmio_hit && (off == OFF_CMP);
    assign wr_ctrl     = MemWrite && mmio_hit && (off == OFF_CTRL);
    assign wr_stat     = MemWrite && mmio_hit && (off == OFF_STAT);
    assign wr_unmapped = MemWrite && !ram_hit && !mmio_mapped;

    assign en         = ctrl[0];
    assign autoreload = ctrl[1];
    assign irq_en     = ctrl[2];

    // A CPU write to COUNT pre-empts the compare for that edge.
    assign cmp_hit = en && (count == cmp) && !wr_cnt;

    always_ff @(posedge clk) begin
        if (MemWrite && ram_hit) begin
            mem[ram_idx] <= WriteData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_q <= '0;
            sync1  <= '0;
            sync2  <= '0;
            count  <= '0;
            cmp    <= 32'hFFFF_FFFF;
            ctrl   <= '0;
            match  <= 1'b0;
            fault  <= 1'b0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;

            if (wr_gout) gpio_q <= WriteData;
            if (wr_cmp)  cmp    <= WriteData;
            if (wr_ctrl) ctrl   <= WriteData[2:0];

            if (wr_cnt) begin
                count <= WriteData;
            end else if (cmp_hit && autoreload) begin
                count <= '0;
            end else if (en) begin
                count <= count + 32'd1;
            end

            // Set events win over a simultaneous write-1-to-clear.
            if (cmp_hit) begin
                match <= 1'b1;
            end else if (wr_stat && WriteData[0]) begin
                match <= 1'b0;
            end

            if (wr_unmapped) begin
                fault <= 1'b1;
            end else if (wr_stat && WriteData[1]) begin
                fault <= 1'b0;
            end
        end
    end

    always_comb begin
        ReadData = '0;
        if (ram_hit) begin
            ReadData = mem[ram_idx];
        end else if (mmio_hit) begin
            case (off)
                OFF_GOUT: ReadData = gpio_q;
                OFF_GIN:  ReadData = sync2;
                OFF_CNT:  ReadData = count;
                OFF_CMP:  ReadData = cmp;
                OFF_CTRL: ReadData = {29'd0, ctrl};
                OFF_STAT: ReadData = {30'd0, fault, match};
                default:  ReadData = '0;
            endcase
        end
    end

    assign gpio_out  = gpio_q;
    assign timer_irq = match && irq_en;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: hand-computed expectations for RAM, GPIO, timer and fault behaviour.
module tb_dmem_mmio;

    localparam logic [31:0] A_GOUT = 32'hFF00;
    localparam logic [31:0] A_GIN  = 32'hFF04;
    localparam logic [31:0] A_HOLE = 32'hFF08;
    localparam logic [31:0] A_CNT  = 32'hFF10;
    localparam logic [31:0] A_CMP  = 32'hFF14;
    localparam logic [31:0] A_CTRL = 32'hFF18;
    localparam logic [31:0] A_STAT = 32'hFF1C;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic        timer_irq;

    int n_cmp = 0;
    int n_err = 0;

    dmem_mmio #(.RAM_WORDS(64), .MMIO_BASE(32'h0000_FF00)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        ALUResult = a;
        WriteData = d;
        MemWrite  = 1'b1;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        MemWrite  = 1'b0;
        ALUResult = a;
        #1;
        chk(tag, ReadData, exp);
    endtask

    initial begin
        logic [31:0] seq_ar [6];
        logic [31:0] seq_wr [3];
        seq_ar = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
        seq_wr = '{32'hFFFF_FFFF, 32'd0, 32'd1};

        reset     = 1'b0;
        MemWrite  = 1'b0;
        ALUResult = '0;
        WriteData = '0;
        gpio_in   = '0;
        tick();
        chk("rst_gpio_out", gpio_out, 32'h0);
        chk("rst_irq", {31'd0, timer_irq}, 32'h0);
        rdchk("rst_cmp", A_CMP, 32'hFFFF_FFFF);
        tick();
        reset = 1'b1;
        tick();

        // Get the timer running with an interrupt pending, then pulse reset between edges.
        wr(A_GOUT, 32'h55);
        wr(A_CMP, 32'd2);
        wr(A_CTRL, 32'h5);
        repeat (3) tick();
        chk("pre_rst_irq", {31'd0, timer_irq}, 32'h1);
        reset = 1'b0;
        #1;
        chk("async_gpio_out", gpio_out, 32'h0);
        chk("async_irq", {31'd0, timer_irq}, 32'h0);
        rdchk("async_ctrl", A_CTRL, 32'h0);
        rdchk("async_count", A_CNT, 32'h0);
        rdchk("async_cmp", A_CMP, 32'hFFFF_FFFF);
        reset = 1'b1;
        tick();
        rdchk("unmapped_hole", A_HOLE, 32'h0);
        rdchk("unmapped_far", 32'h2000, 32'h0);
        rdchk("count_held", A_CNT, 32'h0);

        // RAM
        wr(32'h00, 32'h0102_0304);
        wr(32'h08, 32'h1111_1111);
        wr(32'h0C, 32'hDEAD_BEEF);
        wr(32'h0D, 32'h1234_5678);
        rdchk("ram_byte_ofs", 32'h0C, 32'h1234_5678);
        rdchk("ram_08_old", 32'h08, 32'h1111_1111);
        ALUResult = 32'h08;
        WriteData = 32'hCAFE_F00D;
        MemWrite  = 1'b1;
        #1;
        chk("ram_pre_edge", ReadData, 32'h1111_1111);
        tick();
        MemWrite = 1'b0;
        rdchk("ram_post_edge", 32'h08, 32'hCAFE_F00D);

        // One-shot: match fires on the 6th enabled edge
        wr(A_CMP, 32'd5);
        wr(A_CNT, 32'd0);
        wr(A_CTRL, 32'h5);
        repeat (5) tick();
        rdchk("os_count5", A_CNT, 32'd5);
        chk("os_irq_before", {31'd0, timer_irq}, 32'h0);
        tick();
        chk("os_irq", {31'd0, timer_irq}, 32'h1);
        rdchk("os_count6", A_CNT, 32'd6);
        rdchk("os_stat", A_STAT, 32'h1);
        wr(A_STAT, 32'h1);
        chk("os_irq_clr", {31'd0, timer_irq}, 32'h0);
        rdchk("os_stat_clr", A_STAT, 32'h0);
        wr(A_CTRL, 32'h0);

        // Autoreload and priority
        wr(A_CMP, 32'd3);
        wr(A_CNT, 32'd0);
        wr(A_CTRL, 32'h3);
        for (int i = 0; i < 6; i++) begin
            rdchk($sformatf("ar_seq%0d", i), A_CNT, seq_ar[i]);
            tick();
        end
        rdchk("ar_match", A_STAT, 32'h1);
        tick();
        wr(A_CNT, 32'h100);
        rdchk("ar_cnt_write_wins", A_CNT, 32'h100);
        wr(A_STAT, 32'h1);
        rdchk("ar_stat_clr", A_STAT, 32'h0);
        wr(A_CNT, 32'd2);
        tick();
        wr(A_STAT, 32'h1);
        rdchk("ar_set_wins", A_STAT, 32'h1);
        rdchk("ar_reload", A_CNT, 32'h0);
        wr(A_CTRL, 32'h0);

        // Wrap without match
        wr(A_STAT, 32'h3);
        wr(A_CMP, 32'd10);
        wr(A_CNT, 32'hFFFF_FFFE);
        wr(A_CTRL, 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            rdchk($sformatf("wrap%0d", i), A_CNT, seq_wr[i]);
        end
        rdchk("wrap_no_match", A_STAT, 32'h0);
        wr(A_CTRL, 32'h0);

        // GPIO and fault
        wr(A_GOUT, 32'hA5);
        chk("gpio_out", gpio_out, 32'hA5);
        rdchk("gpio_out_rd", A_GOUT, 32'hA5);
        gpio_in = 32'h3C;
        rdchk("gin_edge0", A_GIN, 32'h0);
        tick();
        rdchk("gin_edge1", A_GIN, 32'h0);
        tick();
        rdchk("gin_edge2", A_GIN, 32'h3C);
        wr(A_GIN, 32'hFFFF_FFFF);
        rdchk("gin_ro", A_GIN, 32'h3C);
        rdchk("gin_ro_nofault", A_STAT, 32'h0);
        wr(32'h4000, 32'h9999_9999);
        rdchk("fault_stat", A_STAT, 32'h2);
        rdchk("fault_ram0", 32'h00, 32'h0102_0304);
        rdchk("fault_ram8", 32'h08, 32'hCAFE_F00D);
        wr(A_STAT, 32'h2);
        rdchk("fault_clr", A_STAT, 32'h0);
        wr(A_HOLE, 32'h1);
        rdchk("fault_hole", A_STAT, 32'h2);
        chk("gpio_out_kept", gpio_out, 32'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
